// File: rtl/frame_tx_pkg.sv
// Shared definitions for the Modbus RTU response transmitter and its CRC engine.
// FSM encodings, frame kinds, function/exception codes and line-timing helper.
package frame_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_FETCH,
        S_SEND,
        S_WAIT,
        S_CRC_L,
        S_CRC_H,
        S_DONE
    } tx_state_t;

    typedef enum logic [2:0] {
        K_EXC,
        K_QERR,
        K_READ,
        K_WRITE,
        K_ILLF
    } frame_kind_t;

    localparam logic [7:0]  FC_RD_HOLD   = 8'h03;
    localparam logic [7:0]  FC_RD_INPUT  = 8'h04;
    localparam logic [7:0]  FC_WR_SINGLE = 8'h06;

    localparam logic [7:0]  EX_ILL_FUNC  = 8'h01;
    localparam logic [7:0]  EX_ILL_VALUE = 8'h03;

    localparam logic [7:0]  MAX_QTY      = 8'd125;

    localparam logic [15:0] CRC_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC_POLY     = 16'hA001;

    // 3.5 character times at 11 bits per character, in clock cycles.
    function automatic int unsigned t35_cycles(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
        return (clk_freq / baud_rate) * 77 / 2;
    endfunction

endpackage

// File: rtl/crc16_serial.sv
// Modbus CRC16 over one byte, one bit per cycle; done pulses 9 cycles after start.
// No backpressure: a new start restarts the computation from crc_i.
module crc16_serial
    import frame_tx_pkg::*;
(
    input  logic        sys_clk,
    input  logic        reset_n,
    input  logic        start_i,
    input  logic [7:0]  byte_i,
    input  logic [15:0] crc_i,
    output logic [15:0] crc_o,
    output logic        done_o
);

    logic [15:0] crc_q, crc_d;
    logic [2:0]  bit_q, bit_d;
    logic        run_q, run_d;
    logic        done_q, done_d;

    always_comb begin
        crc_d  = crc_q;
        bit_d  = bit_q;
        run_d  = run_q;
        done_d = 1'b0;
        if (start_i) begin
            crc_d = crc_i ^ {8'h00, byte_i};
            bit_d = 3'd0;
            run_d = 1'b1;
        end else if (run_q) begin
            crc_d = crc_q[0] ? ((crc_q >> 1) ^ CRC_POLY) : (crc_q >> 1);
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q  <= CRC_INIT;
            bit_q  <= 3'd0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            crc_q  <= crc_d;
            bit_q  <= bit_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign crc_o  = crc_q;
    assign done_o = done_q;

endmodule

// File: rtl/frame_tx.sv
// Modbus RTU slave response transmitter: waits 3.5 chars after tx_start, then streams bytes.
// One byte in flight; next byte starts 1 cycle after byte_tx_done (2 when a DPRAM word is fetched).
module frame_tx
    import frame_tx_pkg::*;
#(
    parameter logic [7:0]  SADDR     = 8'h01,
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD_RATE = 115200,
    parameter int unsigned A_WIDTH   = 8
) (
    input  logic               sys_clk,
    input  logic               reset_n,
    input  logic               tx_start,
    input  logic [7:0]         exception,
    input  logic [7:0]         func_code,
    input  logic [15:0]        addr,
    input  logic [15:0]        data,
    input  logic [7:0]         tx_quantity,
    output logic [A_WIDTH-1:0] dpram_addr,
    input  logic [15:0]        dpram_rdata,
    output logic               byte_tx_start,
    output logic [7:0]         byte_tx_data,
    input  logic               byte_tx_done,
    output logic               busy,
    output logic               frame_done
);

    localparam int unsigned    T35      = t35_cycles(CLK_FREQ, BAUD_RATE);
    localparam int unsigned    GW       = $clog2(T35 + 1);
    localparam logic [GW-1:0]  GAP_LAST = GW'(T35 - 2);

    tx_state_t          state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic [7:0]         lo_q, lo_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic [A_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [15:0]        crc_q, crc_d;
    logic               busy_q, busy_d;

    logic [7:0]  exc_q, func_q, qty_q;
    logic [15:0] addr_q, data_q;

    frame_kind_t kind;
    logic        is_rd_fc;
    logic [7:0]  body_len;
    logic [7:0]  byte_sel;
    logic        accept;
    logic [15:0] crc_out;
    logic        crc_done;

    assign accept   = (state_q == S_IDLE) && tx_start;
    assign is_rd_fc = (func_q == FC_RD_HOLD) || (func_q == FC_RD_INPUT);

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            exc_q  <= 8'h00;
            func_q <= 8'h00;
            qty_q  <= 8'h00;
            addr_q <= 16'h0000;
            data_q <= 16'h0000;
        end else if (accept) begin
            exc_q  <= exception;
            func_q <= func_code;
            qty_q  <= tx_quantity;
            addr_q <= addr;
            data_q <= data;
        end
    end

    always_comb begin
        kind     = K_ILLF;
        body_len = 8'd3;
        if (exc_q != 8'h00) begin
            kind = K_EXC;
        end else if (is_rd_fc && ((qty_q == 8'd0) || (qty_q > MAX_QTY))) begin
            kind = K_QERR;
        end else if (is_rd_fc) begin
            kind     = K_READ;
            body_len = 8'd3 + {qty_q[6:0], 1'b0};
        end else if (func_q == FC_WR_SINGLE) begin
            kind     = K_WRITE;
            body_len = 8'd6;
        end
    end

    // Byte for index cnt_q; read-data high bytes bypass this and come straight from DPRAM.
    always_comb begin
        byte_sel = SADDR;
        if (cnt_q == 8'd1) begin
            byte_sel = ((kind == K_READ) || (kind == K_WRITE)) ? func_q : (func_q | 8'h80);
        end else if (cnt_q == 8'd2) begin
            case (kind)
                K_EXC:   byte_sel = exc_q;
                K_QERR:  byte_sel = EX_ILL_VALUE;
                K_READ:  byte_sel = {qty_q[6:0], 1'b0};
                K_WRITE: byte_sel = addr_q[15:8];
                default: byte_sel = EX_ILL_FUNC;
            endcase
        end else if (cnt_q >= 8'd3) begin
            if (kind == K_WRITE) begin
                case (cnt_q)
                    8'd3:    byte_sel = addr_q[7:0];
                    8'd4:    byte_sel = data_q[15:8];
                    default: byte_sel = data_q[7:0];
                endcase
            end else begin
                byte_sel = lo_q;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        lo_d      = lo_q;
        tx_byte_d = tx_byte_q;
        rd_addr_d = rd_addr_q;
        crc_d     = crc_done ? crc_out : crc_q;
        busy_d    = busy_q;
        case (state_q)
            S_IDLE: begin
                if (tx_start) begin
                    state_d   = S_GAP;
                    cnt_d     = 8'd0;
                    gap_d     = '0;
                    rd_addr_d = '0;
                    crc_d     = CRC_INIT;
                    busy_d    = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d   = S_SEND;
                    tx_byte_d = byte_sel;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            S_FETCH: begin
                state_d   = S_SEND;
                lo_d      = dpram_rdata[7:0];
                tx_byte_d = dpram_rdata[15:8];
            end
            S_SEND: begin
                state_d = S_WAIT;
                cnt_d   = cnt_q + 8'd1;
                // Address advances once a word's low byte has gone out.
                if ((kind == K_READ) && (cnt_q >= 8'd4) && !cnt_q[0]) begin
                    rd_addr_d = rd_addr_q + A_WIDTH'(1);
                end
            end
            S_WAIT: begin
                if (byte_tx_done) begin
                    if (cnt_q == body_len) begin
                        state_d   = S_CRC_L;
                        tx_byte_d = crc_q[7:0];
                    end else if (cnt_q == body_len + 8'd1) begin
                        state_d   = S_CRC_H;
                        tx_byte_d = crc_q[15:8];
                    end else if (cnt_q == body_len + 8'd2) begin
                        state_d = S_DONE;
                    end else if ((kind == K_READ) && (cnt_q >= 8'd3) && cnt_q[0]) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d   = S_SEND;
                        tx_byte_d = byte_sel;
                    end
                end
            end
            S_CRC_L, S_CRC_H: begin
                state_d = S_WAIT;
                cnt_d   = cnt_q + 8'd1;
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            gap_q     <= '0;
            lo_q      <= 8'h00;
            tx_byte_q <= 8'h00;
            rd_addr_q <= '0;
            crc_q     <= CRC_INIT;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            lo_q      <= lo_d;
            tx_byte_q <= tx_byte_d;
            rd_addr_q <= rd_addr_d;
            crc_q     <= crc_d;
            busy_q    <= busy_d;
        end
    end

    crc16_serial u_crc (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .start_i (state_q == S_SEND),
        .byte_i  (tx_byte_q),
        .crc_i   (crc_q),
        .crc_o   (crc_out),
        .done_o  (crc_done)
    );

    assign dpram_addr    = rd_addr_q;
    assign byte_tx_data  = tx_byte_q;
    assign byte_tx_start = (state_q == S_SEND) || (state_q == S_CRC_L) || (state_q == S_CRC_H);
    assign busy          = busy_q;
    assign frame_done    = (state_q == S_DONE);

endmodule

// File: tb/tb_frame_tx.sv
// Directed bench for frame_tx: a default-rate instance for the real silence guard,
// and a 5 MHz instance (T35 = 43*77/2 = 1655) for the remaining frames.
module tb_frame_tx;

    localparam int T35_SLOW = 16709;
    localparam int T35_FAST = 1655;
    localparam int UART_DLY = 20;

    logic        sys_clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        tx_start = 1'b0;
    logic [7:0]  exception = 8'h00;
    logic [7:0]  func_code = 8'h00;
    logic [15:0] addr = 16'h0000;
    logic [15:0] data = 16'h0000;
    logic [7:0]  tx_quantity = 8'h00;
    logic [15:0] dpram_rdata = 16'h0000;
    logic        byte_tx_done = 1'b0;
    logic        sel_fast = 1'b0;

    logic [7:0] s_dpram_addr, f_dpram_addr, s_btx_data, f_btx_data;
    logic       s_btx_start, f_btx_start, s_busy, f_busy, s_fdone, f_fdone;

    logic [7:0] m_addr, m_data;
    logic       m_start, m_busy, m_fdone;

    assign m_addr  = sel_fast ? f_dpram_addr : s_dpram_addr;
    assign m_data  = sel_fast ? f_btx_data   : s_btx_data;
    assign m_start = sel_fast ? f_btx_start  : s_btx_start;
    assign m_busy  = sel_fast ? f_busy       : s_busy;
    assign m_fdone = sel_fast ? f_fdone      : s_fdone;

    frame_tx u_slow (
        .sys_clk       (sys_clk),
        .reset_n       (reset_n),
        .tx_start      (tx_start & ~sel_fast),
        .exception     (exception),
        .func_code     (func_code),
        .addr          (addr),
        .data          (data),
        .tx_quantity   (tx_quantity),
        .dpram_addr    (s_dpram_addr),
        .dpram_rdata   (dpram_rdata),
        .byte_tx_start (s_btx_start),
        .byte_tx_data  (s_btx_data),
        .byte_tx_done  (byte_tx_done),
        .busy          (s_busy),
        .frame_done    (s_fdone)
    );

    frame_tx #(.CLK_FREQ(5000000)) u_fast (
        .sys_clk       (sys_clk),
        .reset_n       (reset_n),
        .tx_start      (tx_start & sel_fast),
        .exception     (exception),
        .func_code     (func_code),
        .addr          (addr),
        .data          (data),
        .tx_quantity   (tx_quantity),
        .dpram_addr    (f_dpram_addr),
        .dpram_rdata   (dpram_rdata),
        .byte_tx_start (f_btx_start),
        .byte_tx_data  (f_btx_data),
        .byte_tx_done  (byte_tx_done),
        .busy          (f_busy),
        .frame_done    (f_fdone)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    logic [15:0] mem [256];
    always @(posedge sys_clk) dpram_rdata <= mem[m_addr];

    // UART stand-in: captures each started byte, answers with done UART_DLY cycles later.
    logic [7:0] cap_q[$];
    logic [7:0] exp_q[$];
    int         st_q[$];
    int         dn_q[$];
    int         uart_cnt = 0;
    int         fd_cnt = 0;
    int         fd_cyc = 0;
    int         hold_err = 0;
    logic [7:0] hold_byte = 8'h00;

    always @(negedge sys_clk) begin
        byte_tx_done = 1'b0;
        if (!reset_n) begin
            uart_cnt = 0;
        end else begin
            if (uart_cnt != 0) begin
                if (m_data != hold_byte) hold_err++;
                uart_cnt--;
                if (uart_cnt == 0) begin
                    byte_tx_done = 1'b1;
                    dn_q.push_back(cyc);
                end
            end
            if (m_start) begin
                cap_q.push_back(m_data);
                st_q.push_back(cyc);
                hold_byte = m_data;
                uart_cnt  = UART_DLY;
            end
            if (m_fdone) begin
                fd_cnt++;
                fd_cyc = cyc;
            end
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic add_crc();
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (exp_q[i]) begin
            c = c ^ {8'h00, exp_q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        exp_q.push_back(c[7:0]);
        exp_q.push_back(c[15:8]);
    endtask

    task automatic pulse_start(input logic [7:0] exc, input logic [7:0] fc,
                               input logic [15:0] a, input logic [15:0] d, input logic [7:0] n);
        exception   = exc;
        func_code   = fc;
        addr        = a;
        data        = d;
        tx_quantity = n;
        tx_start    = 1'b1;
        @(negedge sys_clk);
        tx_start    = 1'b0;
        exception   = 8'h00;
        func_code   = 8'h00;
        addr        = 16'h0000;
        data        = 16'h0000;
        tx_quantity = 8'h00;
    endtask

    task automatic clear_capture();
        cap_q.delete();
        st_q.delete();
        dn_q.delete();
        fd_cnt   = 0;
        hold_err = 0;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] exc, input logic [7:0] fc,
                             input logic [15:0] a, input logic [15:0] d, input logic [7:0] n,
                             input int nrd, input bit dup);
        int t0;
        int eg;
        clear_capture();
        @(negedge sys_clk);
        t0 = cyc;
        pulse_start(exc, fc, a, d, n);
        chk({tag, "/busy_on"}, {31'd0, m_busy}, 1);
        if (dup) begin
            repeat (50) @(negedge sys_clk);
            pulse_start(8'h00, 8'h04, 16'h0000, 16'h0000, 8'd1);
            repeat (T35_FAST + 10) @(negedge sys_clk);
            pulse_start(8'h00, 8'h03, 16'h0000, 16'h0000, 8'd2);
        end
        for (int k = 0; k < 30000 && fd_cnt == 0; k++) @(negedge sys_clk);
        repeat (3) @(negedge sys_clk);
        chk({tag, "/frame_done"}, fd_cnt, 1);
        chk({tag, "/busy_off"}, {31'd0, m_busy}, 0);
        chk({tag, "/len"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < cap_q.size()) chk($sformatf("%s/byte%0d", tag, i), {24'd0, cap_q[i]}, {24'd0, exp_q[i]});
        end
        if (st_q.size() > 0) chk({tag, "/t35"}, st_q[0] - t0, sel_fast ? T35_FAST : T35_SLOW);
        for (int i = 1; i < st_q.size() && i <= dn_q.size(); i++) begin
            eg = (i >= 3 && i < 3 + 2 * nrd && ((i - 3) % 2) == 0) ? 2 : 1;
            chk($sformatf("%s/gap%0d", tag, i), st_q[i] - dn_q[i-1], eg);
        end
        if (dn_q.size() > 0) chk({tag, "/done_lat"}, fd_cyc - dn_q[dn_q.size()-1], 1);
        chk({tag, "/hold"}, hold_err, 0);
    endtask

    initial begin
        #2 reset_n = 1'b0;
        #1;
        chk("rst/slow_outs", {13'd0, s_btx_start, s_btx_data, s_busy, s_fdone, s_dpram_addr}, 0);
        chk("rst/fast_outs", {13'd0, f_btx_start, f_btx_data, f_busy, f_fdone, f_dpram_addr}, 0);
        repeat (3) @(negedge sys_clk);
        reset_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        mem[0] = 16'h0001;
        sel_fast = 1'b0;
        exp_q = '{8'h01, 8'h03, 8'h02, 8'h00, 8'h01, 8'h79, 8'h84};
        run_frame("rd1", 8'h00, 8'h03, 16'h0000, 16'h0000, 8'd1, 1, 1'b0);

        sel_fast = 1'b1;
        exp_q = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B};
        run_frame("wr06", 8'h00, 8'h06, 16'h0001, 16'h0003, 8'd0, 0, 1'b1);

        exp_q = '{8'h01, 8'h83, 8'h02, 8'hC0, 8'hF1};
        run_frame("exc02", 8'h02, 8'h03, 16'h0000, 16'h0000, 8'd1, 0, 1'b0);

        mem[0] = 16'h5347; mem[1] = 16'h7414; mem[2] = 16'h2021; mem[3] = 16'h0402;
        exp_q = '{8'h01, 8'h04, 8'h08, 8'h53, 8'h47, 8'h74, 8'h14, 8'h20, 8'h21, 8'h04, 8'h02};
        add_crc();
        run_frame("rd4", 8'h00, 8'h04, 16'h0000, 16'h0000, 8'd4, 4, 1'b0);

        exp_q = '{8'h01, 8'h83, 8'h03};
        add_crc();
        run_frame("qty0", 8'h00, 8'h03, 16'h0000, 16'h0000, 8'd0, 0, 1'b0);

        exp_q = '{8'h01, 8'h84, 8'h03};
        add_crc();
        run_frame("qty126", 8'h00, 8'h04, 16'h0000, 16'h0000, 8'd126, 0, 1'b0);

        exp_q = '{8'h01, 8'h90, 8'h01};
        add_crc();
        run_frame("fc10", 8'h00, 8'h10, 16'h0000, 16'h0000, 8'd0, 0, 1'b0);

        clear_capture();
        @(negedge sys_clk);
        pulse_start(8'h00, 8'h04, 16'h0000, 16'h0000, 8'd4);
        for (int k = 0; k < 5000 && cap_q.size() < 3; k++) @(negedge sys_clk);
        chk("rst_mid/reach", cap_q.size(), 3);
        reset_n = 1'b0;
        #1;
        chk("rst_mid/outs", {13'd0, f_btx_start, f_btx_data, f_busy, f_fdone, f_dpram_addr}, 0);
        repeat (4) @(negedge sys_clk);
        reset_n = 1'b1;
        repeat (4) @(negedge sys_clk);
        chk("rst_mid/no_done", fd_cnt, 0);

        mem[0] = 16'h0001;
        exp_q = '{8'h01, 8'h03, 8'h02, 8'h00, 8'h01, 8'h79, 8'h84};
        run_frame("post_rst", 8'h00, 8'h03, 16'h0000, 16'h0000, 8'd1, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
